// File: rtl/addr_step_sched.sv
// Shares one +/-1 address-step unit between two round-robin arbitrated burst requesters.
// Optional ADDR_SAT_EN: saturate the address at the ends of the range instead of wrapping.
module addr_step_sched #(
    parameter int unsigned AW = 16,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    dir_up,
    input  logic [AW-1:0] base0,
    input  logic [AW-1:0] base1,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic          abort,
    input  logic          addr_ready,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          addr_valid,
    output logic [AW-1:0] addr,
    output logic          owner,
    output logic          last,
    output logic          wrap,
    output logic [1:0]    done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          rr_prio;
    logic          owner_q;
    logic          dir_q;
    logic [AW-1:0] ptr;
    logic [LW-1:0] cnt;

    logic          grant_c;
    logic          sel_c;
    logic [AW-1:0] sel_base_c;
    logic [LW-1:0] sel_len_c;
    logic          sel_dir_c;
    logic          at_edge_c;
    logic          beat_c;
    logic [AW-1:0] ptr_step_c;

    // Arbitration and address-step datapath
    always_comb begin
        sel_c      = (req == 2'b11) ? rr_prio : req[1];
        grant_c    = (state == S_IDLE) && (req != 2'b00);
        sel_base_c = sel_c ? base1 : base0;
        sel_len_c  = sel_c ? len1 : len0;
        sel_dir_c  = sel_c ? dir_up[1] : dir_up[0];
        at_edge_c  = dir_q ? (ptr == {AW{1'b1}}) : (ptr == '0);
        beat_c     = (state == S_BURST) && addr_ready && !abort;
        ptr_step_c = dir_q ? (ptr + AW'(1)) : (ptr - AW'(1));
`ifdef ADDR_SAT_EN
        if (at_edge_c) begin
            ptr_step_c = ptr;
        end
`else
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_c) begin
                    state_nxt = (sel_len_c == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (addr_ready && (cnt == LW'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; an abort during DONE suppresses the completion pulse
    always_comb begin
        gnt        = 2'b00;
        busy       = (state != S_IDLE);
        addr_valid = (state == S_BURST);
        addr       = ptr;
        owner      = owner_q;
        last       = (state == S_BURST) && (cnt == LW'(1));
        wrap       = (state == S_BURST) && at_edge_c;
        done       = 2'b00;
        if (grant_c) begin
            gnt = sel_c ? 2'b10 : 2'b01;
        end
        if ((state == S_DONE) && !abort) begin
            done = owner_q ? 2'b10 : 2'b01;
        end
    end

    // Burst context: latched at grant, advanced on each accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_prio <= 1'b0;
            owner_q <= 1'b0;
            dir_q   <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else if (grant_c) begin
            owner_q <= sel_c;
            dir_q   <= sel_dir_c;
            ptr     <= sel_base_c;
            cnt     <= sel_len_c;
            if (req == 2'b11) begin
                rr_prio <= ~sel_c;
            end
        end else if (beat_c) begin
            ptr <= ptr_step_c;
            cnt <= cnt - LW'(1);
        end
    end

endmodule

// File: tb/tb_addr_step_sched.sv
// Randomized and directed bench for addr_step_sched against a transaction-level address-list model.
module tb_addr_step_sched;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    dir_up;
    logic [AW-1:0] base0;
    logic [AW-1:0] base1;
    logic [LW-1:0] len0;
    logic [LW-1:0] len1;
    logic          abort;
    logic          addr_ready;
    logic [1:0]    gnt;
    logic          busy;
    logic          addr_valid;
    logic [AW-1:0] addr;
    logic          owner;
    logic          last;
    logic          wrap;
    logic [1:0]    done;

    int   vectors     = 0;
    int   miscompares = 0;
    logic model_prio  = 1'b0;

    always #5 clk = ~clk;

    addr_step_sched #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .req(req), .dir_up(dir_up),
        .base0(base0), .base1(base1), .len0(len0), .len1(len1),
        .abort(abort), .addr_ready(addr_ready),
        .gnt(gnt), .busy(busy), .addr_valid(addr_valid), .addr(addr),
        .owner(owner), .last(last), .wrap(wrap), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. ab: -1 none, <len abort on that beat, ==len abort in the done cycle.
    // b2b: return in the first idle cycle so the next request is granted immediately.
    task automatic run_burst(input logic [1:0] rq, input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                             input logic [LW-1:0] l0, input logic [LW-1:0] l1, input logic [1:0] up,
                             input int ready_pct, input int ab, input bit b2b);
        logic [AW-1:0] exp_addr[$];
        logic          exp_wrap[$];
        logic [AW-1:0] a;
        logic          ch;
        logic          dup;
        int            n;
        int            beats;
        int            guard;
        bit            aborted;
        bit            rdy;

        ch  = (rq == 2'b11) ? model_prio : rq[1];
        if (rq == 2'b11) model_prio = ~ch;
        a   = ch ? b1 : b0;
        n   = int'(ch ? l1 : l0);
        dup = up[ch];
        for (int i = 0; i < n; i++) begin
            bit edge_hit;
            edge_hit = dup ? (a == 16'hFFFF) : (a == 16'h0000);
            exp_addr.push_back(a);
            exp_wrap.push_back(edge_hit);
`ifdef ADDR_SAT_EN
            if (!edge_hit) a = dup ? a + 16'd1 : a - 16'd1;
`else
            a = dup ? a + 16'd1 : a - 16'd1;
`endif
        end

        // Grant cycle; abort in IDLE must not block the grant
        req = rq; base0 = b0; base1 = b1; len0 = l0; len1 = l1; dir_up = up;
        abort = 1'($urandom_range(1));
        addr_ready = 1'($urandom_range(1));
        @(negedge clk);
        chk("gnt", 32'(gnt), ch ? 32'h2 : 32'h1);
        chk("busy_at_gnt", 32'(busy), 32'h0);
        step();
        abort = 1'b0;
        base0 = AW'($urandom); base1 = AW'($urandom);
        len0 = LW'($urandom); len1 = LW'($urandom); dir_up = 2'($urandom);

        beats = 0; guard = 0; aborted = 0;
        while (exp_addr.size() > 0) begin
            rdy = ($urandom_range(99) < ready_pct);
            addr_ready = rdy;
            abort = (beats == ab);
            req = 2'($urandom);
            @(negedge clk);
            chk("valid", 32'(addr_valid), 32'h1);
            chk("addr", 32'(addr), 32'(exp_addr[0]));
            chk("last", 32'(last), (exp_addr.size() == 1) ? 32'h1 : 32'h0);
            chk("wrap", 32'(wrap), 32'(exp_wrap[0]));
            chk("owner", 32'(owner), 32'(ch));
            chk("busy", 32'(busy), 32'h1);
            chk("gnt_in_burst", 32'(gnt), 32'h0);
            chk("done_in_burst", 32'(done), 32'h0);
            if (abort) begin
                step();
                abort = 1'b0;
                aborted = 1;
                break;
            end
            if (rdy) begin
                void'(exp_addr.pop_front());
                void'(exp_wrap.pop_front());
                beats++;
            end
            step();
            guard++;
            if (guard > 1000) begin
                vectors++;
                miscompares++;
                $error("FAIL burst_timeout observed=%0d expected=%0d", beats, n);
                break;
            end
        end

        if (!aborted) begin
            addr_ready = 1'($urandom_range(1));
            abort = (ab == n);
            req = 2'($urandom);
            @(negedge clk);
            chk("done", 32'(done), (ab == n) ? 32'h0 : (ch ? 32'h2 : 32'h1));
            chk("valid_in_done", 32'(addr_valid), 32'h0);
            chk("busy_in_done", 32'(busy), 32'h1);
            chk("gnt_in_done", 32'(gnt), 32'h0);
            step();
            abort = 1'b0;
        end
        req = 2'b00;

        if (!b2b) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_valid", 32'(addr_valid), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
            chk("idle_gnt", 32'(gnt), 32'h0);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; dir_up = 2'b00; base0 = '0; base1 = '0;
        len0 = '0; len1 = '0; abort = 1'b0; addr_ready = 1'b0;
        step();
        @(negedge clk);
        chk("rst_outputs", {gnt, busy, addr_valid, addr, owner, last, wrap, done}, 32'h0);
        step();
        rst = 1'b0;

        // Simple up burst
        run_burst(2'b01, 16'h0010, 16'h0000, 8'd4, 8'd0, 2'b01, 100, -1, 0);
        // Alternation with both requesting
        for (int i = 0; i < 4; i++)
            run_burst(2'b11, 16'h1000, 16'h2000, 8'd2, 8'd2, 2'b11, 100, -1, 0);
        // Down across zero
        run_burst(2'b10, 16'h0000, 16'h0001, 8'd0, 8'd3, 2'b00, 100, -1, 0);
        // Up across the top
        run_burst(2'b01, 16'hFFFE, 16'h0000, 8'd4, 8'd0, 2'b01, 100, -1, 0);
        // Back-pressure
        run_burst(2'b01, 16'h0200, 16'h0000, 8'd5, 8'd0, 2'b01, 40, -1, 0);
        // Abort on 2nd beat, pending request granted right after
        run_burst(2'b01, 16'h0300, 16'h0000, 8'd8, 8'd0, 2'b01, 100, 1, 1);
        run_burst(2'b10, 16'h0000, 16'h0400, 8'd0, 8'd2, 2'b10, 100, -1, 1);
        // Back-to-back right after done
        run_burst(2'b01, 16'h0500, 16'h0000, 8'd1, 8'd0, 2'b00, 100, -1, 0);
        // Abort during the done cycle
        run_burst(2'b01, 16'h0600, 16'h0000, 8'd1, 8'd0, 2'b01, 100, 1, 0);
        // Zero-length
        run_burst(2'b01, 16'h0700, 16'h0000, 8'd0, 8'd0, 2'b01, 100, -1, 0);

        // Reset on the 3rd beat of a channel-1 burst
        req = 2'b10; base1 = 16'h0100; len1 = 8'd8; dir_up = 2'b10; addr_ready = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h2);
        step();
        req = 2'b00;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_beat3_addr", 32'(addr), 32'h0102);
        step();
        rst = 1'b0;
        model_prio = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {gnt, busy, addr_valid, addr, owner, last, wrap, done}, 32'h0);
        step();

        // Randomized transactions
        for (int k = 0; k < 60; k++) begin
            logic [1:0]    rq;
            logic [AW-1:0] rb0;
            logic [AW-1:0] rb1;
            logic [LW-1:0] rl0;
            logic [LW-1:0] rl1;
            int            ab;
            rq  = 2'($urandom_range(2) + 1);
            rb0 = ($urandom_range(2) == 0) ? AW'($urandom_range(3)) :
                  ($urandom_range(1) == 0) ? AW'(16'hFFFC + 16'($urandom_range(3))) : AW'($urandom);
            rb1 = ($urandom_range(2) == 0) ? AW'($urandom_range(3)) :
                  ($urandom_range(1) == 0) ? AW'(16'hFFFC + 16'($urandom_range(3))) : AW'($urandom);
            rl0 = LW'($urandom_range(10));
            rl1 = LW'($urandom_range(10));
            ab  = ($urandom_range(7) == 0) ? $urandom_range(10) : -1;
            run_burst(rq, rb0, rb1, rl0, rl1, 2'($urandom), 30 + $urandom_range(70), ab,
                      1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
